// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand sequencer.
package alu_pkg;
    localparam int STATUS_W  = 6;
    localparam int OP_W      = 5;
    localparam int CARRY_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command / response handshake bundle for alu_op_sequencer.
interface alu_op_sequencer_if #(
    parameter int Width = 16,
    parameter int AddrW = 3
);
    import alu_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [OP_W-1:0]     cmd_op;
    logic [AddrW-1:0]    cmd_rs1;
    logic [AddrW-1:0]    cmd_rs2;
    logic [AddrW-1:0]    cmd_rd;
    logic                cmd_use_carry;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [Width-1:0]    rsp_data;
    logic [STATUS_W-1:0] rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_use_carry, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_use_carry, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/alu_regfile.sv
// NumRegs x Width register file: two combinational reads, two synchronous
// writes. Port 0 (writeback) wins over port 1 (load) on the same address.
module alu_regfile #(
    parameter int Width   = 16,
    parameter int NumRegs = 8,
    parameter int AddrW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AddrW-1:0] rd_addr0,
    output logic [Width-1:0] rd_data0,
    input  logic [AddrW-1:0] rd_addr1,
    output logic [Width-1:0] rd_data1,
    input  logic             we0,
    input  logic [AddrW-1:0] wa0,
    input  logic [Width-1:0] wd0,
    input  logic             we1,
    input  logic [AddrW-1:0] wa1,
    input  logic [Width-1:0] wd1
);
    logic [NumRegs-1:0][Width-1:0] rf_q, rf_d;

    assign rd_data0 = rf_q[rd_addr0];
    assign rd_data1 = rf_q[rd_addr1];

    // Next register contents; port 0 applied last so it overrides port 1.
    always_comb begin
        rf_d = rf_q;
        if (we1) rf_d[wa1] = wd1;
        if (we0) rf_d[wa0] = wd0;
    end

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) rf_q <= '0;
        else     rf_q <= rf_d;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer around a combinational ALU: accept command, drive registered
// operands for one settle cycle, capture result/status, write back, respond.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int Width    = 16,
    parameter int NumRegs  = 8,
    parameter int AddrW    = 3,
    parameter int CarryBit = CARRY_BIT
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus,
    input  logic                ld_en,
    input  logic [AddrW-1:0]    ld_addr,
    input  logic [Width-1:0]    ld_data,
    output logic [Width-1:0]    alu_A,
    output logic [Width-1:0]    alu_B,
    output logic [OP_W-1:0]     alu_F,
    output logic                alu_Cin,
    input  logic [Width-1:0]    alu_Out,
    input  logic [STATUS_W-1:0] alu_Status,
    output logic                carry_flag
);
    seq_state_e          state_q, state_d;
    logic [Width-1:0]    a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]     f_q, f_d;
    logic                cin_q, cin_d;
    logic [AddrW-1:0]    rd_q, rd_d;
    logic [Width-1:0]    rsp_data_q, rsp_data_d;
    logic [STATUS_W-1:0] rsp_status_q, rsp_status_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                carry_q, carry_d;
    logic                wb_en;
    logic [Width-1:0]    rs1_data, rs2_data;

    // Reads see pre-edge contents, so a same-edge load never leaks into operands.
    alu_regfile #(.Width(Width), .NumRegs(NumRegs), .AddrW(AddrW)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (bus.cmd_rs1),
        .rd_data0 (rs1_data),
        .rd_addr1 (bus.cmd_rs2),
        .rd_data1 (rs2_data),
        .we0      (wb_en),
        .wa0      (rd_q),
        .wd0      (alu_Out),
        .we1      (ld_en),
        .wa1      (ld_addr),
        .wd1      (ld_data)
    );

    assign bus.cmd_ready  = (state_q == IDLE) && !rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;
    assign alu_A          = a_q;
    assign alu_B          = b_q;
    assign alu_F          = f_q;
    assign alu_Cin        = cin_q;
    assign carry_flag     = carry_q;

    // Next state, operand latch on accept, capture/writeback at end of EXEC.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        f_d          = f_q;
        cin_d        = cin_q;
        rd_d         = rd_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        rsp_valid_d  = rsp_valid_q;
        carry_d      = carry_q;
        wb_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && bus.cmd_ready) begin
                    a_d     = rs1_data;
                    b_d     = rs2_data;
                    f_d     = bus.cmd_op;
                    cin_d   = bus.cmd_use_carry ? carry_q : 1'b0;
                    rd_d    = bus.cmd_rd;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d   = alu_Out;
                rsp_status_d = alu_Status;
                carry_d      = alu_Status[CarryBit];
                rsp_valid_d  = 1'b1;
                wb_en        = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= '0;
            cin_q        <= 1'b0;
            rd_q         <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= '0;
            rsp_valid_q  <= 1'b0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            f_q          <= f_d;
            cin_q        <= cin_d;
            rd_q         <= rd_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
            rsp_valid_q  <= rsp_valid_d;
            carry_q      <= carry_d;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a combinational ALU stub.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic [4:0]  alu_F;
    logic        alu_Cin, carry_flag;
    logic [5:0]  alu_Status;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] m_rf [8];
    logic        m_carry;

    alu_op_sequencer_if #(.Width(16), .AddrW(3)) bus ();

    alu_op_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_F      (alu_F),
        .alu_Cin    (alu_Cin),
        .alu_Out    (alu_Out),
        .alu_Status (alu_Status),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stub: returns {status, out}; status = {neg, 3'b0, zero, carry}.
    function automatic logic [21:0] alu_stub(input logic [15:0] a, b, input logic [4:0] f, input logic cin);
        logic [16:0] w;
        case (f)
            5'd0:    w = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            5'd1:    w = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            5'd2:    w = {1'b0, a & b};
            5'd3:    w = {1'b0, a | b};
            5'd4:    w = {1'b0, a ^ b};
            default: w = {1'b0, a};
        endcase
        return {w[15], 3'b000, (w[15:0] == 16'd0), w[16], w[15:0]};
    endfunction

    always_comb begin
        {alu_Status, alu_Out} = alu_stub(alu_A, alu_B, alu_F, alu_Cin);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] peek(input int idx);
        return u_dut.u_rf.rf_q[idx];
    endfunction

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!bus.cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_rdy"}, {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic set_cmd(input logic [4:0] op, input logic [2:0] rs1, rs2, rd, input logic uc);
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_rd = rd; bus.cmd_use_carry = uc;
    endtask

    // Full command with rsp_ready=1; keep_valid leaves cmd_valid asserted.
    task automatic issue(input string tag, input logic [4:0] op, input logic [2:0] rs1, rs2, rd,
                         input logic uc, input logic keep_valid);
        logic [21:0] r;
        logic        ec;
        wait_ready(tag);
        set_cmd(op, rs1, rs2, rd, uc);
        bus.rsp_ready = 1'b1;
        ec = uc ? m_carry : 1'b0;
        r  = alu_stub(m_rf[rs1], m_rf[rs2], op, ec);
        @(negedge clk);
        if (!keep_valid) bus.cmd_valid = 1'b0;
        chk({tag, "_A"},    {16'd0, alu_A}, {16'd0, m_rf[rs1]});
        chk({tag, "_B"},    {16'd0, alu_B}, {16'd0, m_rf[rs2]});
        chk({tag, "_F"},    {27'd0, alu_F}, {27'd0, op});
        chk({tag, "_Cin"},  {31'd0, alu_Cin}, {31'd0, ec});
        chk({tag, "_nrdy"}, {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        m_rf[rd] = r[15:0];
        m_carry  = r[16];
        chk({tag, "_vld"},  {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, bus.rsp_data}, {16'd0, r[15:0]});
        chk({tag, "_stat"}, {26'd0, bus.rsp_status}, {26'd0, r[21:16]});
        chk({tag, "_cf"},   {31'd0, carry_flag}, {31'd0, m_carry});
        chk({tag, "_wb"},   {16'd0, peek(rd)}, {16'd0, m_rf[rd]});
        @(negedge clk);
        chk({tag, "_vld0"}, {31'd0, bus.rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [21:0] r;
        logic [15:0] held_data, old_r1;
        logic [5:0]  held_stat;
        int          prev_cyc;

        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
        bus.cmd_rd = '0; bus.cmd_use_carry = 1'b0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_carry = 1'b0;
        @(negedge clk); @(negedge clk);

        // Reset state
        chk("rst_rdy",  {31'd0, bus.cmd_ready}, 32'd0);
        chk("rst_vld",  {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_A",    {16'd0, alu_A}, 32'd0);
        chk("rst_cf",   {31'd0, carry_flag}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", {31'd0, bus.cmd_ready}, 32'd1);

        // Test 1: basic add with hand-computed values
        do_load(3'd1, 16'h00FF);
        do_load(3'd2, 16'h0001);
        set_cmd(5'd0, 3'd1, 3'd2, 3'd3, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("t1_nrdy", {31'd0, bus.cmd_ready}, 32'd0);
        chk("t1_A",    {16'd0, alu_A}, 32'h00FF);
        chk("t1_B",    {16'd0, alu_B}, 32'h0001);
        chk("t1_Cin",  {31'd0, alu_Cin}, 32'd0);
        chk("t1_vld_e",{31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t1_vld",  {31'd0, bus.rsp_valid}, 32'd1);
        chk("t1_data", {16'd0, bus.rsp_data}, 32'h0100);
        chk("t1_stat", {26'd0, bus.rsp_status}, 32'd0);
        chk("t1_r3",   {16'd0, peek(3)}, 32'h0100);
        m_rf[3] = 16'h0100;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_vld0", {31'd0, bus.rsp_valid}, 32'd0);
        chk("t1_rdy",  {31'd0, bus.cmd_ready}, 32'd1);

        // Test 2: carry chain
        do_load(3'd4, 16'hFFFF);
        do_load(3'd5, 16'h0001);
        issue("t2a", 5'd0, 3'd4, 3'd5, 3'd6, 1'b0, 1'b0);
        chk("t2a_cf",   {31'd0, carry_flag}, 32'd1);
        chk("t2a_r6",   {16'd0, peek(6)}, 32'h0000);
        issue("t2b", 5'd0, 3'd2, 3'd2, 3'd7, 1'b1, 1'b0);
        chk("t2b_r7",   {16'd0, peek(7)}, 32'h0003);
        chk("t2b_cf",   {31'd0, carry_flag}, 32'd0);
        issue("t2c", 5'd0, 3'd4, 3'd5, 3'd6, 1'b0, 1'b0);
        issue("t2d", 5'd0, 3'd2, 3'd2, 3'd7, 1'b0, 1'b0);
        chk("t2d_r7",   {16'd0, peek(7)}, 32'h0002);

        // Test 3: backpressure with a held command
        wait_ready("t3");
        set_cmd(5'd4, 3'd1, 3'd3, 3'd4, 1'b0);
        bus.rsp_ready = 1'b0;
        r = alu_stub(m_rf[1], m_rf[3], 5'd4, 1'b0);
        @(negedge clk);
        bus.cmd_op = 5'd2;
        @(negedge clk);
        chk("t3_vld",  {31'd0, bus.rsp_valid}, 32'd1);
        chk("t3_data", {16'd0, bus.rsp_data}, {16'd0, r[15:0]});
        held_data = bus.rsp_data;
        held_stat = bus.rsp_status;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hvld",  {31'd0, bus.rsp_valid}, 32'd1);
            chk("t3_hdata", {16'd0, bus.rsp_data}, {16'd0, held_data});
            chk("t3_hstat", {26'd0, bus.rsp_status}, {26'd0, held_stat});
            chk("t3_nrdy",  {31'd0, bus.cmd_ready}, 32'd0);
            chk("t3_F",     {27'd0, alu_F}, 32'd4);
        end
        m_rf[4] = r[15:0];
        m_carry = r[16];
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("t3_vld0", {31'd0, bus.rsp_valid}, 32'd0);
        chk("t3_rdy",  {31'd0, bus.cmd_ready}, 32'd1);

        // Test 4a: load to rd on the writeback edge loses to writeback
        set_cmd(5'd0, 3'd1, 3'd2, 3'd3, 1'b0);
        r = alu_stub(m_rf[1], m_rf[2], 5'd0, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'hBEEF;
        @(negedge clk);
        ld_en = 1'b0;
        chk("t4a_data", {16'd0, bus.rsp_data}, {16'd0, r[15:0]});
        chk("t4a_r3",   {16'd0, peek(3)}, {16'd0, r[15:0]});
        m_rf[3] = r[15:0];
        m_carry = r[16];
        @(negedge clk);

        // Test 4b: load to rs1 on the accept edge; command sees old value
        old_r1 = m_rf[1];
        set_cmd(5'd0, 3'd1, 3'd2, 3'd7, 1'b0);
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'h1234;
        r = alu_stub(old_r1, m_rf[2], 5'd0, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        ld_en = 1'b0;
        chk("t4b_A",  {16'd0, alu_A}, {16'd0, old_r1});
        chk("t4b_r1", {16'd0, peek(1)}, 32'h1234);
        m_rf[1] = 16'h1234;
        @(negedge clk);
        chk("t4b_data", {16'd0, bus.rsp_data}, {16'd0, r[15:0]});
        m_rf[7] = r[15:0];
        m_carry = r[16];
        @(negedge clk);

        // Test 5: reset during EXEC
        set_cmd(5'd0, 3'd1, 3'd2, 3'd5, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_vld", {31'd0, bus.rsp_valid}, 32'd0);
        chk("t5_cf",  {31'd0, carry_flag}, 32'd0);
        chk("t5_A",   {16'd0, alu_A}, 32'd0);
        chk("t5_rdy_rst", {31'd0, bus.cmd_ready}, 32'd0);
        for (int i = 0; i < 8; i++) chk("t5_reg", {16'd0, peek(i)}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_carry = 1'b0;
        @(negedge clk);
        chk("t5_rdy", {31'd0, bus.cmd_ready}, 32'd1);
        chk("t5_vld2",{31'd0, bus.rsp_valid}, 32'd0);

        // Test 6: back-to-back random commands against the model
        for (int i = 0; i < 8; i++) do_load(i[2:0], 16'($urandom));
        prev_cyc = -1;
        for (int n = 0; n < 100; n++) begin
            if (prev_cyc >= 0 && bus.cmd_ready) chk("t6_gap", cyc - prev_cyc, 32'd3);
            prev_cyc = bus.cmd_ready ? cyc : prev_cyc;
            issue("t6", 5'($urandom_range(0, 6)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
        end
        bus.cmd_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
